// File: rtl/jtag_scan_master.sv
// JTAG scan engine: runs TAP reset, IR scan, DR scan and run-idle commands on tck/tms/tdi, capturing tdo.
// Optional TDO expect/mask comparison is enabled by defining JTAG_TDO_COMPARE_EN.
module jtag_scan_master #(
    parameter int IR_LENGTH   = 4,
    parameter int MAX_DR_BITS = 64,
    parameter int LEN_W       = 8,
    parameter int TCK_DIV     = 2
) (
    input  logic                   clk,
    input  logic                   trst_,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [LEN_W-1:0]       cmd_len,
    input  logic [MAX_DR_BITS-1:0] cmd_data,
`ifdef JTAG_TDO_COMPARE_EN
    input  logic [MAX_DR_BITS-1:0] cmd_expect,
    input  logic [MAX_DR_BITS-1:0] cmd_mask,
    output logic                   rsp_mismatch,
`endif
    output logic                   rsp_valid,
    output logic                   rsp_err,
    output logic [LEN_W-1:0]       rsp_len,
    output logic [MAX_DR_BITS-1:0] rsp_data,
    output logic                   busy,
    output logic                   tck,
    output logic                   tms,
    output logic                   tdi,
    input  logic                   tdo
);
    localparam int DIV_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam logic [1:0] OP_RESET = 2'd0, OP_IR = 2'd1, OP_DR = 2'd2;

    typedef enum logic [3:0] {
        IDLE, RESET, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE, RUN, DONE
    } state_t;

    state_t                 state_reg, state_next;
    logic [DIV_W-1:0]       div_reg, div_next;
    logic [LEN_W-1:0]       cnt_reg, cnt_next;
    logic                   tail_reg, tail_next;
    logic                   tck_reg, tck_next, tms_reg, tms_next, tdi_reg, tdi_next;
    logic [1:0]             op_reg, op_next;
    logic [LEN_W-1:0]       len_reg, len_next;
    logic [MAX_DR_BITS-1:0] data_reg, data_next, cap_reg, cap_next;
    logic                   rsp_err_reg, rsp_err_next;
    logic [LEN_W-1:0]       rsp_len_reg, rsp_len_next;
    logic [MAX_DR_BITS-1:0] rsp_data_reg, rsp_data_next;
    logic                   tick;
    logic [MAX_DR_BITS-1:0] rsp_calc;

    // Captured bits enter at the top, so the first sample must be shifted down to bit 0.
    assign rsp_calc = cap_reg >> (LEN_W'(MAX_DR_BITS) - len_reg);
    assign tick     = (div_reg == DIV_W'(TCK_DIV - 1));

`ifdef JTAG_TDO_COMPARE_EN
    logic [MAX_DR_BITS-1:0] expect_reg, expect_next, mask_reg, mask_next, len_mask;
    logic                   mis_reg, mis_next;
    assign len_mask     = ~({MAX_DR_BITS{1'b1}} << len_reg);
    assign rsp_mismatch = mis_reg;
`endif

    always_comb begin
        state_next    = state_reg;
        div_next      = div_reg;
        cnt_next      = cnt_reg;
        tail_next     = tail_reg;
        tck_next      = tck_reg;
        tms_next      = tms_reg;
        tdi_next      = tdi_reg;
        op_next       = op_reg;
        len_next      = len_reg;
        data_next     = data_reg;
        cap_next      = cap_reg;
        rsp_err_next  = rsp_err_reg;
        rsp_len_next  = rsp_len_reg;
        rsp_data_next = rsp_data_reg;
`ifdef JTAG_TDO_COMPARE_EN
        expect_next   = expect_reg;
        mask_next     = mask_reg;
        mis_next      = mis_reg;
`endif
        case (state_reg)
            IDLE, DONE: begin
                state_next = IDLE;
                if (cmd_valid) begin
                    op_next   = cmd_op;
                    len_next  = cmd_len;
                    data_next = cmd_data;
                    cap_next  = '0;
                    cnt_next  = '0;
                    div_next  = '0;
                    tck_next  = 1'b0;
                    tdi_next  = 1'b0;
                    tail_next = 1'b0;
                    tms_next  = 1'b1;
`ifdef JTAG_TDO_COMPARE_EN
                    expect_next = cmd_expect;
                    mask_next   = cmd_mask;
`endif
                    case (cmd_op)
                        OP_RESET: state_next = RESET;
                        OP_IR: begin
                            state_next = SEL_DR;
                            len_next   = LEN_W'(IR_LENGTH);
                        end
                        OP_DR: begin
                            if (cmd_len == '0 || cmd_len > LEN_W'(MAX_DR_BITS)) begin
                                state_next    = DONE;
                                tms_next      = 1'b0;
                                rsp_err_next  = 1'b1;
                                rsp_len_next  = '0;
                                rsp_data_next = '0;
`ifdef JTAG_TDO_COMPARE_EN
                                mis_next      = 1'b0;
`endif
                            end else begin
                                state_next = SEL_DR;
                            end
                        end
                        default: begin
                            tms_next = 1'b0;
                            if (cmd_len == '0) begin
                                state_next    = DONE;
                                rsp_err_next  = 1'b0;
                                rsp_len_next  = '0;
                                rsp_data_next = '0;
`ifdef JTAG_TDO_COMPARE_EN
                                mis_next      = 1'b0;
`endif
                            end else begin
                                state_next = RUN;
                            end
                        end
                    endcase
                end
            end
            default: begin
                div_next = tick ? '0 : div_reg + DIV_W'(1);
                if (tick) begin
                    if (tail_reg) begin
                        // Final low phase elapsed: publish the response.
                        state_next   = DONE;
                        tail_next    = 1'b0;
                        rsp_err_next = 1'b0;
                        if (op_reg == OP_IR || op_reg == OP_DR) begin
                            rsp_len_next  = len_reg;
                            rsp_data_next = rsp_calc;
                        end else begin
                            rsp_len_next  = '0;
                            rsp_data_next = '0;
                        end
`ifdef JTAG_TDO_COMPARE_EN
                        mis_next = (op_reg == OP_IR || op_reg == OP_DR) &&
                                   (|((rsp_calc ^ expect_reg) & mask_reg & len_mask));
`endif
                    end else if (!tck_reg) begin
                        tck_next = 1'b1;
                        if (state_reg == SHIFT)
                            cap_next = {tdo, cap_reg[MAX_DR_BITS-1:1]};
                    end else begin
                        tck_next = 1'b0;
                        case (state_reg)
                            RESET: begin
                                if (cnt_reg == LEN_W'(5)) begin
                                    tail_next = 1'b1;
                                end else begin
                                    cnt_next = cnt_reg + LEN_W'(1);
                                    tms_next = (cnt_reg < LEN_W'(4));
                                end
                            end
                            SEL_DR: begin
                                state_next = (op_reg == OP_IR) ? SEL_IR : CAPTURE;
                                tms_next   = (op_reg == OP_IR);
                            end
                            SEL_IR: begin
                                state_next = CAPTURE;
                                tms_next   = 1'b0;
                            end
                            CAPTURE: begin
                                // Two TMS=0 cycles: Select->Capture, Capture->Shift.
                                if (cnt_reg == '0) begin
                                    cnt_next = LEN_W'(1);
                                end else begin
                                    state_next = SHIFT;
                                    cnt_next   = '0;
                                    tms_next   = (len_reg == LEN_W'(1));
                                    tdi_next   = data_reg[0];
                                    data_next  = data_reg >> 1;
                                end
                            end
                            SHIFT: begin
                                if (cnt_reg == len_reg - LEN_W'(1)) begin
                                    state_next = EXIT1;
                                    tms_next   = 1'b1;
                                    tdi_next   = 1'b0;
                                end else begin
                                    cnt_next  = cnt_reg + LEN_W'(1);
                                    tms_next  = ((cnt_reg + LEN_W'(2)) == len_reg);
                                    tdi_next  = data_reg[0];
                                    data_next = data_reg >> 1;
                                end
                            end
                            EXIT1: begin
                                state_next = UPDATE;
                                tms_next   = 1'b0;
                            end
                            UPDATE: tail_next = 1'b1;
                            RUN: begin
                                if (cnt_reg == len_reg - LEN_W'(1))
                                    tail_next = 1'b1;
                                else
                                    cnt_next = cnt_reg + LEN_W'(1);
                            end
                            default: ;
                        endcase
                    end
                end
            end
        endcase
    end

    // Reset leaves the FSM in RESET so a TAP reset runs as soon as trst_ drops.
    always_ff @(posedge clk or posedge trst_) begin
        if (trst_) begin
            state_reg    <= RESET;
            div_reg      <= '0;
            cnt_reg      <= '0;
            tail_reg     <= 1'b0;
            tck_reg      <= 1'b0;
            tms_reg      <= 1'b1;
            tdi_reg      <= 1'b0;
            op_reg       <= OP_RESET;
            len_reg      <= '0;
            data_reg     <= '0;
            cap_reg      <= '0;
            rsp_err_reg  <= 1'b0;
            rsp_len_reg  <= '0;
            rsp_data_reg <= '0;
`ifdef JTAG_TDO_COMPARE_EN
            expect_reg   <= '0;
            mask_reg     <= '0;
            mis_reg      <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            div_reg      <= div_next;
            cnt_reg      <= cnt_next;
            tail_reg     <= tail_next;
            tck_reg      <= tck_next;
            tms_reg      <= tms_next;
            tdi_reg      <= tdi_next;
            op_reg       <= op_next;
            len_reg      <= len_next;
            data_reg     <= data_next;
            cap_reg      <= cap_next;
            rsp_err_reg  <= rsp_err_next;
            rsp_len_reg  <= rsp_len_next;
            rsp_data_reg <= rsp_data_next;
`ifdef JTAG_TDO_COMPARE_EN
            expect_reg   <= expect_next;
            mask_reg     <= mask_next;
            mis_reg      <= mis_next;
`endif
        end
    end

    assign cmd_ready = (state_reg == IDLE) || (state_reg == DONE);
    assign busy      = ~cmd_ready;
    assign rsp_valid = (state_reg == DONE);
    assign rsp_err   = rsp_err_reg;
    assign rsp_len   = rsp_len_reg;
    assign rsp_data  = rsp_data_reg;
    assign tck       = tck_reg;
    assign tms       = tms_reg;
    assign tdi       = tdi_reg;
endmodule

// File: tb/tb_jtag_scan_master.sv
// Bench for jtag_scan_master against a behavioural TAP (IDCODE default IR, BYPASS = 4'hF).
// Expected responses are queued at issue time and compared when rsp_valid pulses.
module tb_jtag_scan_master;
    localparam int MAXB = 64;
    localparam int LW   = 8;
    localparam logic [31:0] IDCODE    = 32'h4BA0_0477;
    localparam logic [3:0]  IR_IDCODE = 4'hE;
    localparam logic [3:0]  IR_BYPASS = 4'hF;

    logic            clk = 1'b0;
    logic            trst_ = 1'b1;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [1:0]      cmd_op = 2'd0;
    logic [LW-1:0]   cmd_len = '0;
    logic [MAXB-1:0] cmd_data = '0;
    logic            rsp_valid, rsp_err, busy, tck, tms, tdi;
    logic [LW-1:0]   rsp_len;
    logic [MAXB-1:0] rsp_data;
    logic            tdo = 1'b0;
`ifdef JTAG_TDO_COMPARE_EN
    logic [MAXB-1:0] cmd_expect = '0;
    logic [MAXB-1:0] cmd_mask = '0;
    logic            rsp_mismatch;
`endif

    jtag_scan_master dut (
        .clk(clk), .trst_(trst_), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
`ifdef JTAG_TDO_COMPARE_EN
        .cmd_expect(cmd_expect), .cmd_mask(cmd_mask), .rsp_mismatch(rsp_mismatch),
`endif
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_len(rsp_len), .rsp_data(rsp_data),
        .busy(busy), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
    );

    always #5 clk = ~clk;

    // Behavioural IEEE 1149.1 TAP.
    typedef enum logic [3:0] {
        TLR, RTI, SDS, CDR, SHDR, E1DR, PDR, E2DR, UDR, SIS, CIR, SHIR, E1IR, PIR, E2IR, UIR
    } tap_t;
    tap_t        tap_st = TLR;
    logic [3:0]  tap_ir = IR_IDCODE;
    logic [3:0]  ir_sr = '0;
    logic [31:0] dr_sr = '0;

    function automatic tap_t tap_next(input tap_t s, input logic m);
        case (s)
            TLR:  return m ? TLR  : RTI;
            RTI:  return m ? SDS  : RTI;
            SDS:  return m ? SIS  : CDR;
            CDR:  return m ? E1DR : SHDR;
            SHDR: return m ? E1DR : SHDR;
            E1DR: return m ? UDR  : PDR;
            PDR:  return m ? E2DR : PDR;
            E2DR: return m ? UDR  : SHDR;
            UDR:  return m ? SDS  : RTI;
            SIS:  return m ? TLR  : CIR;
            CIR:  return m ? E1IR : SHIR;
            SHIR: return m ? E1IR : SHIR;
            E1IR: return m ? UIR  : PIR;
            PIR:  return m ? E2IR : PIR;
            E2IR: return m ? UIR  : SHIR;
            default: return m ? SDS : RTI;
        endcase
    endfunction

    always @(posedge tck) begin
        case (tap_st)
            TLR:  tap_ir <= IR_IDCODE;
            CDR:  dr_sr  <= (tap_ir == IR_BYPASS) ? 32'h0 : IDCODE;
            SHDR: dr_sr  <= (tap_ir == IR_BYPASS) ? {31'h0, tdi} : {tdi, dr_sr[31:1]};
            CIR:  ir_sr  <= 4'b0001;
            SHIR: ir_sr  <= {tdi, ir_sr[3:1]};
            UIR:  tap_ir <= ir_sr;
            default: ;
        endcase
        tap_st <= tap_next(tap_st, tms);
    end

    always @(negedge tck)
        tdo <= (tap_st == SHDR) ? dr_sr[0] : (tap_st == SHIR) ? ir_sr[0] : 1'b0;

    // TCK edge counter and TMS history (newest in bit 0).
    int unsigned tck_total = 0;
    logic [31:0] tms_hist = '0;
    always @(posedge tck) begin
        tck_total <= tck_total + 1;
        tms_hist  <= {tms_hist[30:0], tms};
    end

    typedef struct {
        string           tag;
        logic            err;
        logic [LW-1:0]   len;
        logic [MAXB-1:0] data;
        int unsigned     tcks;
        logic            mis;
    } exp_t;
    exp_t        sb_q[$];
    int          errors = 0;
    int          checks = 0;
    int unsigned tck_start = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input string tag, input logic err, input logic [LW-1:0] len,
                            input logic [MAXB-1:0] data, input int unsigned tcks, input logic mis);
        exp_t e;
        e.tag = tag; e.err = err; e.len = len; e.data = data; e.tcks = tcks; e.mis = mis;
        sb_q.push_back(e);
    endtask

    // Wait (bounded) for cmd_ready, queue the expectation, then hold valid for one clk.
    task automatic issue(input string tag, input logic [1:0] op, input logic [LW-1:0] len,
                         input logic [MAXB-1:0] data, input logic exp_err,
                         input logic [LW-1:0] exp_len, input logic [MAXB-1:0] exp_data,
                         input int unsigned exp_tcks, input logic exp_mis);
        int n = 0;
        while (!cmd_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            check({tag, ".ready_timeout"}, 64'(cmd_ready), 64'd1);
            return;
        end
        push_exp(tag, exp_err, exp_len, exp_data, exp_tcks, exp_mis);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        tck_start = tck_total;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_len   = LW'($urandom);
        cmd_data  = {$urandom, $urandom};
`ifdef JTAG_TDO_COMPARE_EN
        cmd_expect = {$urandom, $urandom};
        cmd_mask   = {$urandom, $urandom};
`endif
    endtask

    // Wait (bounded) for rsp_valid, pop the scoreboard and compare; one line per transaction.
    task automatic collect();
        exp_t e;
        int   n = 0;
        while (!rsp_valid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        e = sb_q.pop_front();
        if (!rsp_valid) begin
            check({e.tag, ".rsp_timeout"}, 64'(rsp_valid), 64'd1);
            return;
        end
        check({e.tag, ".err"},   64'(rsp_err),  64'(e.err));
        check({e.tag, ".len"},   64'(rsp_len),  64'(e.len));
        check({e.tag, ".data"},  rsp_data,      e.data);
        check({e.tag, ".tcks"},  64'(tck_total - tck_start), 64'(e.tcks));
        check({e.tag, ".ready"}, 64'(cmd_ready), 64'd1);
`ifdef JTAG_TDO_COMPARE_EN
        check({e.tag, ".mismatch"}, 64'(rsp_mismatch), 64'(e.mis));
`endif
        $display("txn %s: err=%0b len=%0d data=%0h tcks=%0d", e.tag, rsp_err, rsp_len,
                 rsp_data, tck_total - tck_start);
    endtask

    initial begin
        int  n;
        logic seen;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst.tck", 64'(tck), 64'd0);
        check("rst.tms", 64'(tms), 64'd1);
        check("rst.tdi", 64'(tdi), 64'd0);
        check("rst.ready", 64'(cmd_ready), 64'd0);
        check("rst.busy", 64'(busy), 64'd1);
        check("rst.rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst.rsp_len", 64'(rsp_len), 64'd0);
        check("rst.rsp_data", rsp_data, 64'd0);

        // Auto TAP_RESET after release
        push_exp("auto_reset", 1'b0, '0, '0, 6, 1'b0);
        tck_start = tck_total;
        trst_ = 1'b0;
        collect();
        check("auto_reset.tms_seq", 64'(tms_hist[5:0]), 64'b111110);
        @(negedge clk);
        check("idle.rsp_pulse", 64'(rsp_valid), 64'd0);
        check("idle.ready", 64'(cmd_ready), 64'd1);
        check("idle.tck", 64'(tck), 64'd0);
        check("idle.tms", 64'(tms), 64'd0);

        // IDCODE scan, then IR=BYPASS and a 1-bit-delayed DR scan
        issue("dr_idcode", 2'd2, 8'd32, '0, 1'b0, 8'd32, 64'(IDCODE), 37, 1'b0);
        collect();
        issue("ir_bypass", 2'd1, 8'd0, 64'hF, 1'b0, 8'd4, 64'h1, 10, 1'b0);
        collect();
        issue("dr_bypass", 2'd2, 8'd8, 64'hA5, 1'b0, 8'd8, 64'h4A, 13, 1'b0);
        collect();

        // Run-idle and illegal lengths
        issue("run10", 2'd3, 8'd10, '0, 1'b0, '0, '0, 10, 1'b0);
        collect();
        check("run10.tms_low", 64'(tms_hist[9:0]), 64'd0);
        issue("run0", 2'd3, 8'd0, '0, 1'b0, '0, '0, 0, 1'b0);
        collect();
        issue("dr_len0", 2'd2, 8'd0, 64'hFF, 1'b1, '0, '0, 0, 1'b0);
        collect();
        issue("dr_len65", 2'd2, 8'd65, 64'hFF, 1'b1, '0, '0, 0, 1'b0);
        collect();

        // Reset mid DR shift at bit 12 (rising edge 16 of the scan)
        issue("dr_abort", 2'd2, 8'd32, '0, 1'b0, 8'd32, 64'(IDCODE), 37, 1'b0);
        n = 0;
        while ((tck_total - tck_start) < 16 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("abort.reached_bit12", 64'(tck_total - tck_start), 64'd16);
        trst_ = 1'b1;
        #1;
        check("abort.tck", 64'(tck), 64'd0);
        check("abort.tms", 64'(tms), 64'd1);
        check("abort.busy", 64'(busy), 64'd1);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check("abort.no_rsp", 64'(seen), 64'd0);
        sb_q.delete();
        push_exp("abort_reset", 1'b0, '0, '0, 6, 1'b0);
        tck_start = tck_total;
        trst_ = 1'b0;
        collect();
        issue("dr_idcode2", 2'd2, 8'd32, '0, 1'b0, 8'd32, 64'(IDCODE), 37, 1'b0);
        collect();

`ifdef JTAG_TDO_COMPARE_EN
        cmd_expect = 64'(IDCODE ^ 32'h1);
        cmd_mask   = 64'h1;
        issue("cmp_mask1", 2'd2, 8'd32, '0, 1'b0, 8'd32, 64'(IDCODE), 37, 1'b1);
        collect();
        cmd_expect = 64'(IDCODE ^ 32'h1);
        cmd_mask   = 64'h0;
        issue("cmp_mask0", 2'd2, 8'd32, '0, 1'b0, 8'd32, 64'(IDCODE), 37, 1'b0);
        collect();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog");
    end
endmodule
